// File: rtl/tone_pkg.sv
// Shared definitions for the speaker tone arbiter: sound codes, FSM states and
// the per-code half-period lookup.
package tone_pkg;

    localparam logic [2:0] S_RED    = 3'd0;
    localparam logic [2:0] S_GREEN  = 3'd1;
    localparam logic [2:0] S_YELLOW = 3'd2;
    localparam logic [2:0] S_BLUE   = 3'd3;
    localparam logic [2:0] S_WIN    = 3'd4;
    localparam logic [2:0] S_LOSS   = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StGap
    } state_e;

    // Cycles between speaker toggles; silent codes keep a nominal value.
    function automatic logic [3:0] half_period(input logic [2:0] code);
        logic [3:0] h;
        case (code)
            S_RED:    h = 4'd4;
            S_GREEN:  h = 4'd5;
            S_YELLOW: h = 4'd6;
            S_BLUE:   h = 4'd7;
            S_WIN:    h = 4'd8;
            S_LOSS:   h = 4'd3;
            default:  h = 4'd4;
        endcase
        return h;
    endfunction

    function automatic logic is_silent(input logic [2:0] code);
        return code[2] & code[1];
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles speaker every half_period(code) cycles while en
// is high; counter and output clear synchronously whenever en is low.
module tone_gen
    import tone_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] code,
    output logic       speaker
);

    logic [3:0] cnt_q;
    logic       spk_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            spk_q <= 1'b0;
        end else if (!en) begin
            cnt_q <= '0;
            spk_q <= 1'b0;
        end else if (cnt_q == half_period(code) - 4'd1) begin
            cnt_q <= '0;
            spk_q <= ~spk_q & ~is_silent(code);
        end else begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign speaker = spk_q;

endmodule

// File: rtl/tone_arbiter.sv
// Round-robin arbiter sharing one tone generator between several sound
// requesters; latches the winner's code and duration and pulses done at the end.
module tone_arbiter
    import tone_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DUR_W   = 6,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [3*NUM_REQ-1:0]     sound,
    input  logic [DUR_W*NUM_REQ-1:0] dur,
    input  logic                     abort,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [2:0]               cur_sound,
    output logic                     speaker
);

    localparam int unsigned RrW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_e             state_q, state_d;
    logic [RrW-1:0]     rr_q, rr_d;
    logic [DUR_W-1:0]   dcnt_q, dcnt_d;
    logic [GapW-1:0]    gcnt_q, gcnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic [2:0]         snd_q, snd_d;
    logic               tone_en;

    logic [RrW-1:0]     idx;
    logic [RrW-1:0]     pick;
    logic               found;
    logic [NUM_REQ-1:0] pick_oh;
    logic [2:0]         pick_snd;
    logic [DUR_W-1:0]   pick_dur;

    // First requester at or after rr, scanning upwards with wrap.
    always_comb begin
        idx   = '0;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = RrW'((32'(rr_q) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        pick_oh  = '0;
        pick_snd = '0;
        pick_dur = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (RrW'(i) == pick) begin
                pick_oh[i] = 1'b1;
                pick_snd   = sound[3*i +: 3];
                pick_dur   = dur[DUR_W*i +: DUR_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        dcnt_d  = dcnt_q;
        gcnt_d  = gcnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        snd_d   = snd_q;
        tone_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StPlay;
                    gnt_d   = pick_oh;
                    snd_d   = pick_snd;
                    dcnt_d  = (pick_dur == '0) ? DUR_W'(1) : pick_dur;
                    rr_d    = (pick == RrW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                end
            end
            StPlay: begin
                if (dcnt_q == DUR_W'(1) || abort) begin
                    done_d = gnt_q;
                    gnt_d  = '0;
                    snd_d  = '0;
                    gcnt_d = '0;
                    state_d = (GAP_CYC == 0) ? StIdle : StGap;
                end else begin
                    dcnt_d  = dcnt_q - DUR_W'(1);
                    // Held low on entry and exit so speaker is 0 in both edge cycles.
                    tone_en = 1'b1;
                end
            end
            StGap: begin
                if (gcnt_q == GapW'(GAP_CYC - 1)) begin
                    state_d = StIdle;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            rr_q    <= '0;
            dcnt_q  <= '0;
            gcnt_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            snd_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            dcnt_q  <= dcnt_d;
            gcnt_q  <= gcnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            snd_q   <= snd_d;
        end
    end

    tone_gen u_tone_gen (
        .clock   (clock),
        .reset   (reset),
        .en      (tone_en),
        .code    (snd_q),
        .speaker (speaker)
    );

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign cur_sound = snd_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Scoreboard bench for tone_arbiter: expected grants are queued when requests are
// driven and checked by a monitor as each sound plays out and completes.
module tb_tone_arbiter;

    localparam int GAP_CYC = 2;

    logic        clock;
    logic        reset;
    logic [2:0]  req;
    logic [8:0]  sound;
    logic [17:0] dur;
    logic        abort;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic        busy;
    logic [2:0]  cur_sound;
    logic        speaker;

    tone_arbiter #(
        .NUM_REQ (3),
        .DUR_W   (6),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .sound     (sound),
        .dur       (dur),
        .abort     (abort),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .cur_sound (cur_sound),
        .speaker   (speaker)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int who;
        int snd;
        int len;
        int tog;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    exp_t dropped;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_seen = 0;
    int   last_done_cyc = 0;
    bit   b2b_armed = 1'b0;
    bit   in_play   = 1'b0;
    int   len, tog, spk_err, h, snap;
    logic prev_spk, exp_spk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int tb_half(input int code);
        case (code)
            0: return 4;
            1: return 5;
            2: return 6;
            3: return 7;
            4: return 8;
            5: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic void push(input int who, input int snd, input int plen);
        exp_t e;
        int   hp;
        hp    = tb_half(snd);
        e.who = who;
        e.snd = snd;
        e.len = plen;
        e.tog = (hp == 0) ? 0 : (plen - 1) / hp;
        sb.push_back(e);
    endfunction

    // Monitor: measures each grant's length, toggles and waveform against the queue head.
    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            in_play = 1'b0;
        end else begin
            if (|done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    check_val("spurious_done", 32'(done), 0);
                end else begin
                    cur = sb.pop_front();
                    check_val("done_who", 32'(done), 32'(1) << cur.who);
                    check_val("play_len", len, cur.len);
                    check_val("toggles", tog, cur.tog);
                    check_val("spk_wave_err", spk_err, 0);
                    check_val("gap_speaker", 32'(speaker), 0);
                    check_val("gap_cur_sound", 32'(cur_sound), 0);
                    check_val("gap_gnt", 32'(gnt), 0);
                    check_val("gap_busy", 32'(busy), 1);
                end
                in_play = 1'b0;
                last_done_cyc = cyc;
            end
            if (|gnt) begin
                if (!in_play) begin
                    in_play  = 1'b1;
                    len      = 0;
                    tog      = 0;
                    spk_err  = 0;
                    prev_spk = 1'b0;
                    if (sb.size() == 0) begin
                        check_val("unexpected_gnt", 32'(gnt), 0);
                    end else begin
                        check_val("gnt_who", 32'(gnt), 32'(1) << sb[0].who);
                        check_val("cur_sound", 32'(cur_sound), sb[0].snd);
                    end
                    if (b2b_armed) check_val("gap_len", cyc - last_done_cyc, GAP_CYC + 1);
                end
                if (sb.size() > 0) begin
                    h = tb_half(sb[0].snd);
                    exp_spk = (h == 0) ? 1'b0 : 1'((len / h) % 2);
                    if (speaker !== exp_spk) spk_err++;
                end
                if (speaker !== prev_spk) tog++;
                prev_spk = speaker;
                len++;
            end
        end
    end

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (done == '0 && n < max_cyc);
        if (done == '0) check_val("done_timeout", 32'(done), 1);
    endtask

    task automatic wait_gnt(input int max_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (gnt == '0 && n < max_cyc);
        if (gnt == '0) check_val("gnt_timeout", 32'(gnt), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_gnt"}, 32'(gnt), 0);
        check_val({tag, "_done"}, 32'(done), 0);
        check_val({tag, "_busy"}, 32'(busy), 0);
        check_val({tag, "_cur_sound"}, 32'(cur_sound), 0);
        check_val({tag, "_speaker"}, 32'(speaker), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        req   = '0;
        sound = '0;
        dur   = '0;
        abort = 1'b0;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;

        // Single request: code 2 (H=6), 20 cycles.
        @(negedge clock);
        sound = {3'd0, 3'd0, 3'd2};
        dur   = {6'd0, 6'd0, 6'd20};
        req   = 3'b001;
        push(0, 2, 20);
        @(negedge clock);
        check_val("req_to_gnt", 32'(gnt), 1);
        check_val("busy_in_play", 32'(busy), 1);
        wait_done(100);
        req = '0;
        @(negedge clock);
        check_val("busy_gap_end", 32'(busy), 1);
        @(negedge clock);
        check_val("busy_idle", 32'(busy), 0);

        // Round-robin with all requests held; reset first so rr starts at 0.
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        sound = {3'd5, 3'd3, 3'd0};
        dur   = {6'd7, 6'd15, 6'd9};
        push(0, 0, 9);
        push(1, 3, 15);
        push(2, 5, 7);
        push(0, 0, 9);
        req = 3'b111;
        wait_gnt(10);
        wait_done(100);
        b2b_armed = 1'b1;
        wait_done(100);
        wait_done(100);
        wait_gnt(10);
        req = '0;
        wait_done(100);
        b2b_armed = 1'b0;
        repeat (4) @(negedge clock);

        // Abort on PLAY cycle 5 of a 30-cycle win fanfare.
        sound = {3'd0, 3'd0, 3'd4};
        dur   = {6'd0, 6'd0, 6'd30};
        req   = 3'b001;
        push(0, 4, 6);
        wait_gnt(10);
        repeat (5) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check_val("abort_done", 32'(done), 1);
        check_val("abort_speaker", 32'(speaker), 0);
        req = '0;
        @(negedge clock);
        snap  = done_seen;
        abort = 1'b1;
        repeat (3) @(negedge clock);
        abort = 1'b0;
        repeat (6) @(negedge clock);
        check_val("abort_single_done", done_seen, snap);
        check_val("abort_idle_busy", 32'(busy), 0);

        // Zero duration with a silent code.
        sound = {3'd0, 3'd0, 3'd7};
        dur   = {6'd0, 6'd0, 6'd0};
        req   = 3'b001;
        push(0, 7, 1);
        wait_done(20);
        req = '0;
        repeat (4) @(negedge clock);

        // Reset during PLAY cycle 10 with requester 1 pending.
        sound = {3'd0, 3'd2, 3'd1};
        dur   = {6'd0, 6'd5, 6'd40};
        req   = 3'b001;
        push(0, 1, 40);
        wait_gnt(10);
        repeat (10) @(negedge clock);
        req  = 3'b011;
        snap = done_seen;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        dropped = sb.pop_front();
        req = 3'b010;
        repeat (3) @(negedge clock);
        check_val("reset_no_done", done_seen, snap);
        push(1, 2, 5);
        reset = 1'b1;
        wait_gnt(10);
        check_val("post_reset_winner", 32'(gnt), 2);
        wait_done(20);
        req = '0;
        repeat (5) @(negedge clock);
        check_val("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
